// File: rtl/prefetch_queue.sv
// Sequential byte prefetcher: 4-phase MMU byte handshake feeding a DEPTH-entry FIFO.
// `byte` is a reserved word in SystemVerilog, so the MMU read-data port is named byte_in.
module prefetch_queue #(
   parameter int ADDR_SIZE = 32,
   parameter int DEPTH     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   strb,
   output logic                   rw,
   output logic [ADDR_SIZE-1:0]   mar,
   input  logic                   mfc,
   input  logic [7:0]             byte_in,
   input  logic                   flush,
   input  logic [ADDR_SIZE-1:0]   flush_addr,
   input  logic                   q_pop,
   output logic [7:0]             q_byte,
   output logic                   q_valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [1:0]           state_q,   state_d;
   logic                 strb_q,    strb_d;
   logic [ADDR_SIZE-1:0] mar_q,     mar_d;
   logic [ADDR_SIZE-1:0] fptr_q,    fptr_d;
   logic                 discard_q, discard_d;
   logic [CW-1:0]        count_q,   count_d;
   logic [PW-1:0]        rd_ptr_q,  rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q,  wr_ptr_d;
   logic [7:0]           mem_q [DEPTH];
   logic                 push;
   logic                 pop;

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      strb_d    = strb_q;
      mar_d     = mar_q;
      fptr_d    = fptr_q;
      discard_d = discard_q;
      push      = 1'b0;

      case (state_q)
         IDLE: begin
            // Starting only below FULL reserves the slot the returning byte will use.
            if (!flush && (count_q < FULL)) begin
               state_d = REQ;
               strb_d  = 1'b1;
               mar_d   = fptr_q;
            end
         end
         REQ: begin
            if (mfc) begin
               state_d = RELEASE;
               strb_d  = 1'b0;
               if (!discard_q && !flush) begin
                  push   = 1'b1;
                  fptr_d = fptr_q + 1'b1;
               end
            end
         end
         RELEASE: begin
            if (!mfc) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            strb_d  = 1'b0;
         end
      endcase

      pop = q_pop && (count_q != '0) && !flush;

      if (flush) begin
         fptr_d   = flush_addr;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         if (state_q != IDLE) discard_d = 1'b1;
      end else begin
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
      end

      if (state_d == IDLE) discard_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         strb_q    <= 1'b0;
         mar_q     <= '0;
         fptr_q    <= '0;
         discard_q <= 1'b0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         strb_q    <= strb_d;
         mar_q     <= mar_d;
         fptr_q    <= fptr_d;
         discard_q <= discard_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
      end
   end

   // NOTE: the storage array is not reset; count_q alone decides which entries are visible.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= byte_in;
   end

   assign strb    = strb_q;
   assign rw      = 1'b1;
   assign mar     = mar_q;
   assign count   = count_q;
   assign q_valid = (count_q != '0);
   assign q_byte  = q_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: responding MMU model, transaction-level queue model, directed and random scenarios.
module tb_prefetch_queue;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strb, rw, q_valid;
   logic        mfc = 1'b0;
   logic        flush = 1'b0;
   logic        q_pop = 1'b0;
   logic [31:0] mar;
   logic [31:0] flush_addr = '0;
   logic [7:0]  byte_in = '0;
   logic [7:0]  q_byte;
   logic [3:0]  count;

   int vectors = 0;
   int miscompares = 0;
   int mmu_lat = 2;
   int mmu_cnt = 0;

   // Reference model: byte queue plus handshake phase (0 idle, 1 strobe out, 2 release).
   logic [7:0]  mq[$];
   logic [31:0] m_ptr = '0;
   logic [31:0] m_req = '0;
   int          m_phase = 0;
   bit          m_disc = 1'b0;
   bit          cap_hit = 1'b0;

   prefetch_queue #(.ADDR_SIZE(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .strb(strb), .rw(rw), .mar(mar), .mfc(mfc),
      .byte_in(byte_in), .flush(flush), .flush_addr(flush_addr), .q_pop(q_pop),
      .q_byte(q_byte), .q_valid(q_valid), .count(count)
   );

   always #5 clk = ~clk;

   // MMU: raises mfc mmu_lat cycles after seeing strb, returns byte = address low bits, releases when strb drops.
   always @(negedge clk) begin
      if (strb !== 1'b1) begin
         mfc = 1'b0;
         mmu_cnt = 0;
      end else if (!mfc) begin
         mmu_cnt++;
         if (mmu_cnt >= mmu_lat) begin
            mfc = 1'b1;
            byte_in = mar[7:0];
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input bit pop_on_cap);
      logic s_rst, s_flush, s_pop, s_mfc;
      logic [31:0] s_faddr;
      int pre_sz, pre_phase;
      @(negedge clk);
      #1;
      if (pop_on_cap && strb && mfc) begin
         q_pop = 1'b1;
         cap_hit = 1'b1;
      end
      s_rst = rst; s_flush = flush; s_pop = q_pop; s_mfc = mfc; s_faddr = flush_addr;
      @(posedge clk);
      if (s_rst) begin
         mq.delete();
         m_ptr = '0; m_req = '0; m_phase = 0; m_disc = 1'b0;
      end else begin
         pre_sz = mq.size();
         pre_phase = m_phase;
         if (s_pop && pre_sz > 0 && !s_flush) void'(mq.pop_front());
         case (m_phase)
            0: if (!s_flush && pre_sz < DEPTH) begin m_phase = 1; m_req = m_ptr; end
            1: if (s_mfc) begin
                  m_phase = 2;
                  if (!m_disc && !s_flush) begin mq.push_back(m_req[7:0]); m_ptr = m_ptr + 1; end
               end
            default: if (!s_mfc) m_phase = 0;
         endcase
         if (s_flush) begin
            mq.delete();
            m_ptr = s_faddr;
            if (pre_phase != 0) m_disc = 1'b1;
         end
         if (m_phase == 0) m_disc = 1'b0;
      end
      #1;
   endtask

   task automatic wait_strb_rise(input int max, output bit ok);
      logic prev;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         prev = strb;
         tick(1'b0);
         if (strb && !prev) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b1; q_pop = 1'b1; flush_addr = 32'hDEAD_BEEF;
      repeat (3) tick(1'b0);
      vectors++; if (strb !== 1'b0) begin miscompares++; $display("FAIL reset_strb: got %b want 0", strb); end
      vectors++; if (rw !== 1'b1) begin miscompares++; $display("FAIL reset_rw: got %b want 1", rw); end
      vectors++; if (mar !== 32'h0) begin miscompares++; $display("FAIL reset_mar: got %h want 0", mar); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (q_valid !== 1'b0) begin miscompares++; $display("FAIL reset_qvalid: got %b want 0", q_valid); end
      vectors++; if (q_byte !== 8'h00) begin miscompares++; $display("FAIL reset_qbyte: got %h want 00", q_byte); end
      // First cycle out of reset: request from address 0, pop on empty queue ignored.
      rst = 1'b0; flush = 1'b0; q_pop = 1'b1;
      tick(1'b0);
      q_pop = 1'b0;
      vectors++; if (strb !== 1'b1) begin miscompares++; $display("FAIL first_strb: got %b want 1", strb); end
      vectors++; if (mar !== 32'h0) begin miscompares++; $display("FAIL first_mar: got %h want 0", mar); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL pop_empty_count: got %0d want 0", count); end
      vectors++; if (q_byte !== 8'h00) begin miscompares++; $display("FAIL pop_empty_qbyte: got %h want 00", q_byte); end
   endtask

   task automatic test_fill();
      logic [31:0] exp_mar;
      logic prev;
      int rises;
      bit any_strb;
      flush = 1'b1; flush_addr = 32'h100;
      tick(1'b0);
      flush = 1'b0;
      exp_mar = 32'h100; rises = 0;
      for (int i = 0; i < 400 && count != 4'd8; i++) begin
         prev = strb;
         tick(1'b0);
         if (strb && !prev) begin
            vectors++; if (mar !== exp_mar) begin miscompares++; $display("FAIL fill_mar: got %h want %h", mar, exp_mar); end
            exp_mar++; rises++;
         end
      end
      vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count: got %0d want 8", count); end
      vectors++; if (rises != 8) begin miscompares++; $display("FAIL fill_requests: got %0d want 8", rises); end
      any_strb = 1'b0;
      repeat (12) begin tick(1'b0); any_strb |= strb; end
      vectors++; if (any_strb !== 1'b0) begin miscompares++; $display("FAIL full_no_strb: got %b want 0", any_strb); end
      vectors++; if (mar !== 32'h107) begin miscompares++; $display("FAIL full_mar: got %h want 00000107", mar); end
   endtask

   task automatic test_pop_refill();
      vectors++; if (q_byte !== 8'h00) begin miscompares++; $display("FAIL head0: got %h want 00", q_byte); end
      q_pop = 1'b1; tick(1'b0); q_pop = 1'b0;
      vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL pop_count: got %0d want 7", count); end
      vectors++; if (strb !== 1'b0) begin miscompares++; $display("FAIL pop_strb_early: got %b want 0", strb); end
      tick(1'b0);
      vectors++; if (strb !== 1'b1) begin miscompares++; $display("FAIL refill_strb: got %b want 1", strb); end
      vectors++; if (mar !== 32'h108) begin miscompares++; $display("FAIL refill_mar: got %h want 00000108", mar); end
      vectors++; if (q_byte !== 8'h01) begin miscompares++; $display("FAIL head1: got %h want 01", q_byte); end
      q_pop = 1'b1; tick(1'b0); q_pop = 1'b0;
      vectors++; if (q_byte !== 8'h02) begin miscompares++; $display("FAIL head2: got %h want 02", q_byte); end
   endtask

   task automatic test_flush_mid();
      bit ok;
      flush = 1'b1; flush_addr = 32'h104; tick(1'b0); flush = 1'b0;
      wait_strb_rise(30, ok);
      vectors++; if (!ok || mar !== 32'h104) begin miscompares++; $display("FAIL redirect_mar: got %h ok=%b want 00000104", mar, ok); end
      flush = 1'b1; flush_addr = 32'h2000; tick(1'b0); flush = 1'b0;
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", count); end
      vectors++; if (strb !== 1'b1 || mar !== 32'h104) begin miscompares++; $display("FAIL flush_hold: got strb=%b mar=%h want 1/00000104", strb, mar); end
      wait_strb_rise(30, ok);
      vectors++; if (!ok || mar !== 32'h2000) begin miscompares++; $display("FAIL flush_new_mar: got %h ok=%b want 00002000", mar, ok); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL dropped_byte: got count %0d want 0", count); end
      for (int i = 0; i < 20 && count == 4'd0; i++) tick(1'b0);
      vectors++; if (q_byte !== 8'h00 || count !== 4'd1) begin miscompares++; $display("FAIL flush_first_byte: got %h cnt %0d want 00/1", q_byte, count); end
   endtask

   task automatic test_push_pop();
      flush = 1'b1; flush_addr = 32'h300; tick(1'b0); flush = 1'b0;
      for (int i = 0; i < 100 && !(count == 4'd3 && strb); i++) tick(1'b0);
      cap_hit = 1'b0;
      for (int i = 0; i < 10 && !cap_hit; i++) tick(1'b1);
      q_pop = 1'b0;
      vectors++; if (cap_hit !== 1'b1) begin miscompares++; $display("FAIL pushpop_sync: got %b want 1", cap_hit); end
      vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL pushpop_count: got %0d want 3", count); end
      for (int k = 1; k <= 3; k++) begin
         vectors++; if (q_byte !== 8'(k)) begin miscompares++; $display("FAIL pushpop_order: got %h want %h", q_byte, 8'(k)); end
         q_pop = 1'b1; tick(1'b0); q_pop = 1'b0;
      end
   endtask

   task automatic test_wrap();
      bit ok;
      flush = 1'b1; flush_addr = 32'hFFFF_FFFF; tick(1'b0); flush = 1'b0;
      wait_strb_rise(30, ok);
      vectors++; if (!ok || mar !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_last: got %h ok=%b want ffffffff", mar, ok); end
      wait_strb_rise(30, ok);
      vectors++; if (!ok || mar !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got %h ok=%b want 00000000", mar, ok); end
      vectors++; if (q_byte !== 8'hFF) begin miscompares++; $display("FAIL wrap_byte: got %h want ff", q_byte); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 40 && !strb; i++) tick(1'b0);
      rst = 1'b1; tick(1'b0);
      vectors++; if (strb !== 1'b0) begin miscompares++; $display("FAIL rst_mid_strb: got %b want 0", strb); end
      flush = 1'b1; q_pop = 1'b1; flush_addr = 32'h55;
      tick(1'b0);
      vectors++; if (count !== 4'd0 || mar !== 32'h0) begin miscompares++; $display("FAIL rst_priority: got cnt %0d mar %h want 0/0", count, mar); end
      rst = 1'b0; flush = 1'b0; q_pop = 1'b0;
   endtask

   task automatic test_random();
      int bias;
      logic [3:0] exp_c;
      logic [7:0] exp_b;
      rst = 1'b1; repeat (2) tick(1'b0); rst = 1'b0;
      bias = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) bias = $urandom_range(0, 100);
         flush = ($urandom_range(0, 29) == 0);
         flush_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
         q_pop = ($urandom_range(0, 99) < bias);
         if ($urandom_range(0, 15) == 0) mmu_lat = $urandom_range(1, 4);
         tick(1'b0);
         exp_c = 4'(mq.size());
         exp_b = (mq.size() > 0) ? mq[0] : 8'h00;
         vectors++; if (count !== exp_c) begin miscompares++; $display("FAIL rnd_count @%0d: got %0d want %0d", i, count, exp_c); end
         vectors++; if (q_valid !== (exp_c != 0)) begin miscompares++; $display("FAIL rnd_qvalid @%0d: got %b", i, q_valid); end
         vectors++; if (q_byte !== exp_b) begin miscompares++; $display("FAIL rnd_qbyte @%0d: got %h want %h", i, q_byte, exp_b); end
         vectors++; if (strb !== (m_phase == 1)) begin miscompares++; $display("FAIL rnd_strb @%0d: got %b want %b", i, strb, m_phase == 1); end
         if (m_phase == 1) begin
            vectors++; if (mar !== m_req) begin miscompares++; $display("FAIL rnd_mar @%0d: got %h want %h", i, mar, m_req); end
         end
      end
      flush = 1'b0; q_pop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop_refill();
      test_flush_mid();
      test_push_pop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE, default 32, giving the byte-address width.
REQ-002 The module SHALL have parameter DEPTH, default 8, giving the queue capacity in bytes (power of two, minimum 2).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-high.
REQ-005 Port strb  output  1  is the byte-request strobe to the MMU byte port.
REQ-006 Port rw  output  1  is the MMU direction bit; 1 = read.
REQ-007 Port mar  output  ADDR_SIZE  is the byte address presented to the MMU.
REQ-008 Port mfc  input  1  is memory-function-complete from the MMU.
REQ-009 Port byte  input  8  is read data from the MMU, valid while mfc=1.
REQ-010 Port flush  input  1  is the redirect request from the consumer.
REQ-011 Port flush_addr  input  ADDR_SIZE  is the new fetch address, sampled when flush=1.
REQ-012 Port q_pop  input  1  means the consumer takes the head byte this cycle.
REQ-013 Port q_byte  output  8  is the head byte of the queue.
REQ-014 Port q_valid  output  1  means the queue is non-empty.
REQ-015 Port count  output  $clog2(DEPTH)+1  is the number of bytes held.

Function
REQ-016 The block SHALL prefetch sequential bytes from the MMU into a DEPTH-entry FIFO, read-only; rw SHALL be constant 1.
REQ-017 The FSM SHALL have the states IDLE, REQ and RELEASE, and SHALL hold a 1-bit discard flag.
REQ-018 IDLE -> REQ when count < DEPTH and flush=0; on that edge mar <= fetch pointer and strb <= 1.
REQ-019 In REQ, strb and mar SHALL stay stable until mfc is sampled 1.
REQ-020 When mfc is sampled 1 in REQ, the FSM SHALL go to RELEASE with strb <= 0.
REQ-021 On that same edge, if discard=0, byte SHALL be pushed and fetch pointer <= fetch pointer + 1, modulo 2^ADDR_SIZE.
REQ-022 RELEASE -> IDLE when mfc is sampled 0 (4-phase handshake); no new strb SHALL be issued before this.
REQ-023 Latency: from IDLE with space available, strb SHALL rise 1 cycle later.
REQ-024 Latency: a byte captured at edge N SHALL appear in count and q_valid after edge N.
REQ-025 With the queue empty, a captured byte SHALL be on q_byte with q_valid=1 in the next cycle; there is no bypass from byte to q_byte.
REQ-026 q_pop with q_valid=0 SHALL be ignored.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and keep byte order.
REQ-028 A request SHALL not start at count=DEPTH; a pop in REQ cannot cause overflow, because the slot is reserved when strb rises.
REQ-029 Flush SHALL empty the queue (count <= 0), set fetch pointer <= flush_addr, and ignore q_pop in that cycle.
REQ-030 Flush in REQ or RELEASE SHALL set discard=1; the handshake completes with strb/mar unchanged, and the byte is dropped and the pointer not incremented.
REQ-031 discard SHALL clear on return to IDLE.
REQ-032 Flush in IDLE SHALL block a request start that cycle; fetch from flush_addr begins next cycle.
REQ-033 Repeated flushes SHALL leave the last flush_addr in effect.
REQ-034 q_byte SHALL be 8'h00 when q_valid=0.
REQ-035 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-036 While rst=1: state IDLE, strb=0, rw=1, mar=0, fetch pointer 0, count 0, q_valid 0, q_byte 8'h00, discard 0.
REQ-037 rst has priority over flush, q_pop and mfc.
REQ-038 rst mid-handshake SHALL drop strb next edge; the bench MMU SHALL then see strb=0 and release mfc.

Verification
REQ-039 After reset, flush with flush_addr=32'h100 and an MMU returning byte = addr[7:0] with 2-cycle mfc: q_byte pops 8'h00, 8'h01, 8'h02 in order; mar steps 100,101,102.
REQ-040 With no pops: count reaches 8, strb stays 0, and mar ends at 32'h107 from the last request.
REQ-041 With count=8 and one pop: count=7 then strb rises next cycle with mar=32'h108.
REQ-042 Flush to 32'h2000 while strb=1 at mar=32'h104: that byte is dropped, count=0, and the next strb arrives after mfc low with mar=32'h2000.
REQ-043 A pop coinciding with the mfc capture at count=3: count stays 3 and the order is preserved.
REQ-044 Pointer at 32'hFFFFFFFF: the next request mar=32'h00000000.
